// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU); one quotient bit per cycle.
// Latency WIDTH+1 edges normal, 2 edges for divide-by-zero/overflow; start ignored while busy.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [1:0]       funct,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_count;
  logic             r_rem_sel;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;

  logic             w_signed, w_s1, w_s2, w_div0, w_ovf;
  logic [WIDTH-1:0] w_mag1, w_mag2, w_special_res;
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix;

  assign w_signed = ~funct[0];
  assign w_s1     = w_signed & op1[WIDTH-1];
  assign w_s2     = w_signed & op2[WIDTH-1];
  assign w_mag1   = w_s1 ? -op1 : op1;
  assign w_mag2   = w_s2 ? -op2 : op2;
  assign w_div0   = (op2 == '0);
  assign w_ovf    = w_signed && (op1 == MIN_NEG) && (op2 == '1);
  assign w_special_res = w_div0 ? (funct[1] ? op1 : '1)
                                : (funct[1] ? '0  : op1);

  // Shifted partial remainder needs WIDTH+1 bits; a set top bit already guarantees it exceeds the divisor.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_div};
  assign w_ge      = w_shift[WIDTH] | ~w_trial[WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_count   <= '0;
      r_rem_sel <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          valid_out <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            r_state   <= CALC;
            r_count   <= CNT_W'(WIDTH-1);
            r_rem     <= '0;
            r_div     <= w_mag2;
            r_rem_sel <= funct[1];
            r_neg_q   <= w_s1 ^ w_s2;
            r_neg_r   <= w_s1;
            r_special <= w_div0 | w_ovf;
            // Special cases park their final answer in the quotient register for one cycle.
            r_quo     <= (w_div0 | w_ovf) ? w_special_res : w_mag1;
          end
        end
        CALC: begin
          if (r_special) begin
            result    <= r_quo;
            valid_out <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_count == '0) begin
              result    <= r_rem_sel ? w_rem_fix : w_quo_fix;
              valid_out <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        DONE: begin
          valid_out <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a behavioural RISC-V division model.
module tb_seq_divider;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] op1, op2;
  logic [1:0]   funct;
  logic         busy, valid_out;
  logic [W-1:0] result;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [W-1:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2), .funct(funct),
    .busy(busy), .valid_out(valid_out), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (valid_out === 1'b1) pulses <= pulses + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] f);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (b == '0) return f[1] ? a : '1;
    if (!f[0]) begin
      if (a == MIN && b == '1) return f[1] ? '0 : a;
      return f[1] ? W'(sa % sb) : W'(sa / sb);
    end
    return f[1] ? (a % b) : (a / b);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drives one operation; optionally raises a stray start sampled at edge E<interfere>.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] f, input logic [W-1:0] expv, input int interfere);
    int n, lat, p0;
    logic [W-1:0] e;
    lat = (b == '0 || (!f[0] && a == MIN && b == '1)) ? 1 : W;
    exp_q.push_back(expv);
    op1 = a; op2 = b; funct = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_E0"}, W'(busy), W'(1));
    p0 = pulses;
    n = 0;
    while (valid_out !== 1'b1 && n < W + 8) begin
      @(posedge clk); #1;
      n++;
      start = (interfere > 0 && n + 1 == interfere);
      if (start) begin op1 = 32'h0000_1234; op2 = 32'h3; funct = 2'b01; end
    end
    start = 1'b0;
    check({tag, " latency"}, W'(n), W'(lat));
    check({tag, " busy_at_valid"}, W'(busy), W'(1));
    e = exp_q.pop_front();
    check({tag, " result"}, result, e);
    @(posedge clk); #1;
    check({tag, " valid_fell"}, W'(valid_out), W'(0));
    check({tag, " busy_fell"}, W'(busy), W'(0));
    check({tag, " result_held"}, result, e);
    check({tag, " one_pulse"}, W'(pulses - p0), W'(1));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return MIN;
      1: return '0;
      2: return W'(1);
      3: return '1;
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int p0;
    logic [W-1:0] a, b;
    logic [1:0] f;
    rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; funct = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", W'(busy), W'(0));
    check("reset valid", W'(valid_out), W'(0));
    check("reset result", result, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7", 32'd100, 32'd7, 2'b01, 32'd14, 0);
    run_op("remu_100_7", 32'd100, 32'd7, 2'b11, 32'd2, 0);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 2'b10, 32'hFFFF_FFFF, 0);
    run_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, 2'b10, 32'd1, 0);
    run_op("divu_by0", 32'd5, 32'd0, 2'b01, 32'hFFFF_FFFF, 0);
    run_op("div_by0", 32'd5, 32'd0, 2'b00, 32'hFFFF_FFFF, 0);
    run_op("rem_by0", 32'd5, 32'd0, 2'b10, 32'd5, 0);
    run_op("remu_by0", 32'd5, 32'd0, 2'b11, 32'd5, 0);
    run_op("div_ovf", MIN, 32'hFFFF_FFFF, 2'b00, MIN, 0);
    run_op("rem_ovf", MIN, 32'hFFFF_FFFF, 2'b10, 32'd0, 0);
    run_op("divu_ovf_ops", MIN, 32'hFFFF_FFFF, 2'b01, 32'd0, 0);
    run_op("divu_stray_start", 32'd100, 32'd7, 2'b01, 32'd14, 5);

    // Abort mid-operation: rst sampled at E10.
    op1 = 32'd100; op2 = 32'd7; funct = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", W'(busy), W'(0));
    check("abort valid", W'(valid_out), W'(0));
    check("abort result", result, '0);
    rst = 1'b0;
    p0 = pulses;
    repeat (W + 4) @(posedge clk);
    #1;
    check("abort no_pulse", W'(pulses - p0), W'(0));

    run_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 2'b01, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 40; i++) begin
      a = pick();
      b = pick();
      f = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d_f%0d", i, f), a, b, f, model(a, b, f), 0);
    end

    check("scoreboard empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
